uart_axil_responder: RTL
========================

// Module: uart_axil_responder
// PURPOSE
// - AXI4-Lite responder terminating the chipset UART port (13-bit addr, 32-bit data); exposes TX/RX byte FIFOs and uart_irq.
// - Sits in the chipset clock domain between the AXI-Lite crossbar and the serial PHY, which consumes the TX and RX byte streams.
// PARAMETERS
// - ADDR_WIDTH  13  AXI-Lite address width; only addr[3:2] decoded, addr[1:0] ignored
// - TX_DEPTH    16  TX FIFO entries; power of two, >=2
// - RX_DEPTH    16  RX FIFO entries; power of two, >=2
// PORTS
// - chipset_clk     in   1   sole clock
// - chipset_rst_n   in   1   asynchronous active-low reset
// - s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_WIDTH/1/1  write address channel
// - s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1  write data channel
// - s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  write response channel
// - s_araddr/s_arvalid/s_arready  in/in/out  ADDR_WIDTH/1/1  read address channel
// - s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1  read data channel
// - tx_data/tx_valid/tx_ready  out/out/in  8/1/1  byte stream to PHY (head of TX FIFO)
// - rx_data/rx_valid/rx_ready  in/in/out  8/1/1  byte stream from PHY into RX FIFO
// - uart_irq        out  1   level interrupt, registered
// BEHAVIOUR
// - Reset: all readies, s_bvalid, s_rvalid, uart_irq = 0; s_bresp/s_rresp/s_rdata = 0; FIFOs empty; sticky flags and irq_en = 0.
// - Map: 0x0 RXDATA (RO, pop), 0x4 TXDATA (WO, push), 0x8 STATUS (RO), 0xC CONTROL (RW); RO/WO mismatch or any other offset -> SLVERR (2'b10).
// - STATUS: [0] rx_nonempty [1] rx_full [2] tx_empty [3] tx_full [4] irq_en [5] tx_ovr [6] rx_ovr; [31:7]=0; read clears [6:5].
// - CONTROL: [0] tx_flush, [1] rx_flush (write-1, self-clearing, read as 0), [4] irq_en (persistent).
// - Write path: AW and W captured independently into one-entry holding regs; s_awready=!aw_held&&!s_bvalid, s_wready=!w_held&&!s_bvalid.
// - When both held, register side effect and s_bvalid rise on the same edge (one cycle after the later of the two handshakes); holds cleared at s_bvalid&&s_bready.
// - One write outstanding; s_bvalid, s_bresp stable until s_bready.
// - TXDATA: wstrb[0]=1 pushes wdata[7:0]; if TX full, byte dropped, tx_ovr set, bresp still OKAY. wstrb[0]=0 -> no push, OKAY.
// - CONTROL write honours wstrb[0] only; other lanes ignored.
// - Read path: s_arready=!s_rvalid; s_rvalid and s_rdata one cycle after AR handshake; held until s_rready. One read outstanding.
// - RXDATA read: non-empty -> rdata={24'b0,head}, pop at AR-accept edge; empty -> rdata=0, no pop, OKAY.
// - rx_ready=!rx_full; rx_valid&&!rx_ready sets rx_ovr (byte lost). tx_valid=!tx_empty; pop on tx_valid&&tx_ready.
// - Simultaneous push+pop on a full or empty FIFO: both allowed only if legal before the edge (full: pop frees, push blocked by ready; empty: push only).
// - Flush same cycle as pop/push: flush wins, FIFO empty next cycle; an RXDATA read captured that edge still returns the pre-flush head.
// - STATUS read same edge as sticky set: captured value shows 0, flag set afterwards (set wins over clear).
// - uart_irq registered: irq_en & rx_nonempty (next-cycle update).
// - Reset asserted mid-transaction: all state cleared immediately; partially captured AW/W discarded, no response issued.
// CONFIGURATION
// - UART_AXIL_TX_EMPTY_IRQ_EN defined: sticky tx_drained flag set when TX FIFO goes non-empty->empty;
//   uart_irq also = irq_en & tx_drained; cleared by STATUS read or TXDATA push; visible as STATUS[7].
// - Undefined: no tx_drained logic, STATUS[7] reads 0, irq from RX only.
// TESTING
// - Write 0x41,0x42 to 0x4, tx_ready=1 -> tx_data 0x41 then 0x42, bresp OKAY, STATUS[2]=1 afterwards.
// - 17 TXDATA writes with tx_ready=0 -> 16 stored, STATUS=0x28 (tx_full+tx_ovr); second STATUS read shows [5]=0.
// - Drive rx bytes 0x55,0xAA; read 0x0 twice then again -> 0x55, 0xAA, then 0x00 OKAY; STATUS[0]=0.
// - Write CONTROL=0x10, push rx byte -> uart_irq=1 two cycles after rx handshake; read RXDATA -> uart_irq=0.
// - Read 0x4, write 0x0, write 0x10 -> SLVERR each, no FIFO change; W before AW by 3 cycles -> single bvalid.
// - Hold s_rready/s_bready=0 10 cycles -> rvalid/bvalid and data stable, arready/awready=0; assert reset mid-write -> all outputs 0.

Source files
------------

// File: rtl/uart_axil_responder.sv
// UART AXI4-Lite responder: 4-register map over TX/RX byte FIFOs with a registered level interrupt.
// Build option: define UART_AXIL_TX_EMPTY_IRQ_EN to add the sticky tx_drained flag (STATUS[7]) as an irq source.

module uart_axil_responder_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q == {~rd_q[AW], rd_q[AW-1:0]});
  assign dout_o  = empty_o ? 8'h00 : mem_q[rd_q[AW-1:0]];

  // Flush wins over any push/pop presented on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + ONE;
      if (pop_i && !empty_o) rd_q <= rd_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

module uart_axil_responder #(
  parameter int ADDR_WIDTH = 13,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic                  chipset_clk,
  input  logic                  chipset_rst_n,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  uart_irq
);
  localparam logic [1:0] OKAY        = 2'b00;
  localparam logic [1:0] SLVERR      = 2'b10;
  localparam logic [1:0] OFF_RXDATA  = 2'd0;
  localparam logic [1:0] OFF_TXDATA  = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;

  logic        alive_q, aw_held_q, w_held_q, w_strb0_q;
  logic [1:0]  aw_off_q, bresp_q, rresp_q;
  logic [7:0]  w_dat_q;
  logic        bvalid_q, rvalid_q, irq_en_q, tx_ovr_q, rx_ovr_q, irq_q;
  logic [31:0] rdata_q;

  logic        aw_fire, w_fire, ar_fire, wr_exec, wr_tx, wr_ctrl, stat_rd;
  logic        tx_empty, tx_full, rx_empty, rx_full, tx_drained;
  logic [7:0]  tx_head, rx_head;
  logic [1:0]  ar_off, wr_resp, rd_resp;
  logic [31:0] status, rd_dat;
  logic        unused_bits;

  assign unused_bits = ^{s_awaddr[ADDR_WIDTH-1:4], s_awaddr[1:0], s_araddr[ADDR_WIDTH-1:4],
                         s_araddr[1:0], s_wdata[31:8], s_wstrb[3:1]};

  // alive_q keeps every ready low while reset is held and for the first cycle after it.
  assign s_awready = alive_q && !aw_held_q && !bvalid_q;
  assign s_wready  = alive_q && !w_held_q && !bvalid_q;
  assign s_arready = alive_q && !rvalid_q;
  assign rx_ready  = alive_q && !rx_full;
  assign tx_valid  = !tx_empty;
  assign tx_data   = tx_head;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign uart_irq  = irq_q;

  assign aw_fire = s_awvalid && s_awready;
  assign w_fire  = s_wvalid && s_wready;
  assign ar_fire = s_arvalid && s_arready;
  assign ar_off  = s_araddr[3:2];
  assign wr_exec = aw_held_q && w_held_q && !bvalid_q;
  assign wr_tx   = wr_exec && (aw_off_q == OFF_TXDATA) && w_strb0_q;
  assign wr_ctrl = wr_exec && (aw_off_q == 2'd3) && w_strb0_q;
  assign stat_rd = ar_fire && (ar_off == OFF_STATUS);
  assign wr_resp = (aw_off_q == OFF_TXDATA || aw_off_q == 2'd3) ? OKAY : SLVERR;
  assign status  = {24'd0, tx_drained, rx_ovr_q, tx_ovr_q, irq_en_q, tx_full, tx_empty, rx_full, !rx_empty};

  always_comb begin
    rd_dat  = '0;
    rd_resp = OKAY;
    case (ar_off)
      OFF_RXDATA: rd_dat = {24'd0, rx_head};
      OFF_TXDATA: rd_resp = SLVERR;
      OFF_STATUS: rd_dat = status;
      default:    rd_dat = {27'd0, irq_en_q, 4'd0};
    endcase
  end

  uart_axil_responder_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(chipset_clk), .rst_n(chipset_rst_n), .flush_i(wr_ctrl && w_dat_q[0]),
    .push_i(wr_tx), .din_i(w_dat_q), .pop_i(tx_valid && tx_ready),
    .dout_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
  );

  uart_axil_responder_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(chipset_clk), .rst_n(chipset_rst_n), .flush_i(wr_ctrl && w_dat_q[1]),
    .push_i(rx_valid && rx_ready), .din_i(rx_data), .pop_i(ar_fire && (ar_off == OFF_RXDATA)),
    .dout_o(rx_head), .empty_o(rx_empty), .full_o(rx_full)
  );

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      alive_q   <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_off_q  <= '0;
      w_dat_q   <= '0;
      w_strb0_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      irq_en_q  <= 1'b0;
      tx_ovr_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (aw_fire) begin
        aw_held_q <= 1'b1;
        aw_off_q  <= s_awaddr[3:2];
      end
      if (w_fire) begin
        w_held_q  <= 1'b1;
        w_dat_q   <= s_wdata[7:0];
        w_strb0_q <= s_wstrb[0];
      end
      if (wr_exec) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
      end else if (bvalid_q && s_bready) begin
        bvalid_q  <= 1'b0;
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
      if (ar_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_dat;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && s_rready) begin
        rvalid_q <= 1'b0;
      end
      if (wr_ctrl) irq_en_q <= w_dat_q[4];
      // A STATUS read returns the pre-edge flags; a set on the same edge survives the clear.
      tx_ovr_q <= (tx_ovr_q && !stat_rd) || (wr_tx && tx_full);
      rx_ovr_q <= (rx_ovr_q && !stat_rd) || (rx_valid && alive_q && rx_full);
      irq_q    <= irq_en_q && (!rx_empty || tx_drained);
    end
  end

`ifdef UART_AXIL_TX_EMPTY_IRQ_EN
  logic tx_drained_q, tx_empty_prev_q;
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      tx_drained_q    <= 1'b0;
      tx_empty_prev_q <= 1'b1;
    end else begin
      tx_empty_prev_q <= tx_empty;
      tx_drained_q    <= (tx_drained_q && !stat_rd && !wr_tx) || (tx_empty && !tx_empty_prev_q);
    end
  end
  assign tx_drained = tx_drained_q;
`else
  assign tx_drained = 1'b0;
`endif
endmodule
